// File: rtl/key_sel3_if.sv
// key_sel3_if: groups the raw push-button pins and the selection outputs
// of key_sel3 into one bundle.
//   key_up_n  : raw UP button, active-low, asynchronous
//   key_dn_n  : raw DOWN button, active-low, asynchronous
//   key_clr_n : raw CLEAR button, active-low, asynchronous
//   sel       : current 3-bit selection code (feeds decode38.sw)
//   sel_chg   : one-cycle pulse when sel takes a new accepted value
// master drives the buttons and observes the outputs; slave is key_sel3.
interface key_sel3_if;
  logic       key_up_n;
  logic       key_dn_n;
  logic       key_clr_n;
  logic [2:0] sel;
  logic       sel_chg;

  modport master (
    output key_up_n,
    output key_dn_n,
    output key_clr_n,
    input  sel,
    input  sel_chg
  );

  modport slave (
    input  key_up_n,
    input  key_dn_n,
    input  key_clr_n,
    output sel,
    output sel_chg
  );
endinterface

// File: rtl/key_sel3.sv
// key_sel3: debounced UP/DOWN/CLEAR push-button front end that keeps a
// 3-bit wrap-around selection counter for the decode38 3-8 decoder.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : key_sel3_if.slave (raw keys in, sel / sel_chg out)
// Parameters:
//   DB_CYCLES : cycles a synchronized key level must hold to be accepted
//   CNT_W     : debounce counter width, 2**CNT_W > DB_CYCLES
module key_sel3 #(
  parameter int DB_CYCLES = 240000,
  parameter int CNT_W     = 20
) (
  input logic       clk,
  input logic       rst_n,
  key_sel3_if.slave bus
);

  // Key index: 0 = UP, 1 = DOWN, 2 = CLEAR
  localparam int NKEY = 3;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NKEY-1:0]  keys_raw;
  logic [NKEY-1:0]  sync1_q;
  logic [NKEY-1:0]  key_s_q;
  logic [NKEY-1:0]  stable_q, stable_d;
  logic [NKEY-1:0]  edge_q;
  logic [NKEY-1:0]  armed_q, armed_d;
  logic [NKEY-1:0]  press;
  logic [CNT_W-1:0] cnt_q     [NKEY];
  logic [CNT_W-1:0] cnt_d     [NKEY];
  logic [CNT_W-1:0] arm_cnt_q [NKEY];
  logic [CNT_W-1:0] arm_cnt_d [NKEY];
  logic [2:0]       sel_q, sel_d;
  logic             sel_chg_q, sel_chg_d;

  assign keys_raw = {bus.key_clr_n, bus.key_dn_n, bus.key_up_n};

  // Debounce plus arming. A key is only armed once it has been seen
  // released for DB_CYCLES after reset (or a release has been accepted),
  // so a key held through reset never produces a press event.
  always_comb begin
    stable_d = stable_q;
    armed_d  = armed_q;
    for (int k = 0; k < NKEY; k++) begin
      cnt_d[k]     = '0;
      arm_cnt_d[k] = '0;
      if (key_s_q[k] != stable_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          stable_d[k] = key_s_q[k];
          if (key_s_q[k]) begin
            armed_d[k] = 1'b1;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
      if (!armed_q[k] && key_s_q[k] && stable_q[k]) begin
        if (arm_cnt_q[k] == DB_LAST) begin
          armed_d[k] = 1'b1;
        end else begin
          arm_cnt_d[k] = arm_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Press event: accepted 1->0 transition of an armed key.
  assign press = edge_q & ~stable_q & armed_q;

  // Selection update with CLR > (UP and DN cancel) > UP > DN priority.
  always_comb begin
    sel_d     = sel_q;
    sel_chg_d = 1'b0;
    if (press[2]) begin
      sel_d     = 3'b000;
      sel_chg_d = 1'b1;
    end else if (press[0] && press[1]) begin
      sel_d     = sel_q;
      sel_chg_d = 1'b0;
    end else if (press[0]) begin
      sel_d     = sel_q + 3'd1;
      sel_chg_d = 1'b1;
    end else if (press[1]) begin
      sel_d     = sel_q - 3'd1;
      sel_chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      key_s_q   <= '1;
      stable_q  <= '1;
      edge_q    <= '1;
      armed_q   <= '0;
      for (int k = 0; k < NKEY; k++) begin
        cnt_q[k]     <= '0;
        arm_cnt_q[k] <= '0;
      end
      sel_q     <= 3'b000;
      sel_chg_q <= 1'b0;
    end else begin
      sync1_q   <= keys_raw;
      key_s_q   <= sync1_q;
      stable_q  <= stable_d;
      edge_q    <= stable_q;
      armed_q   <= armed_d;
      for (int k = 0; k < NKEY; k++) begin
        cnt_q[k]     <= cnt_d[k];
        arm_cnt_q[k] <= arm_cnt_d[k];
      end
      sel_q     <= sel_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sel_chg = sel_chg_q;

endmodule
